// File: rtl/issue_queue_if.sv
// Bundle of the fetch-side and dispatch-side handshakes of issue_queue.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where the producer's *_vld and the consumer's *_rdy are both high and
// the queue is enabled (rdy_in high, flush low). While *_vld is high the
// payload must stay stable until it is taken. in_rdy never depends on
// in_vld, and out_vld never depends on out_rdy.
interface issue_queue_if;
    logic        in_vld;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        in_rdy;

    logic        out_vld;
    logic        out_rdy;
    logic        out_rs1_hv;
    logic        out_rs2_hv;
    logic        out_rd_hv;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [3:0]  out_optype;
    logic [3:0]  out_opcode;
    logic        out_ill;

    // Fetch/dispatch environment side
    modport master (
        output in_vld, in_ins, in_pc, out_rdy,
        input  in_rdy, out_vld, out_rs1_hv, out_rs2_hv, out_rd_hv,
               out_rs1, out_rs2, out_rd, out_imm, out_pc,
               out_optype, out_opcode, out_ill
    );

    // Queue side
    modport slave (
        input  in_vld, in_ins, in_pc, out_rdy,
        output in_rdy, out_vld, out_rs1_hv, out_rs2_hv, out_rd_hv,
               out_rs1, out_rs2, out_rd, out_imm, out_pc,
               out_optype, out_opcode, out_ill
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: decodes RV32I words at the fetch boundary and buffers the
// decoded entries (with their pc) in a DEPTH-entry circular FIFO that the
// dispatch logic pops with valid/ready. Flush empties the queue, rdy_in low
// freezes everything.
//
// Optional feature macro: ISSUE_ILL_CHK_EN. When defined, words with an
// unrecognised major opcode are enqueued as illegal entries (out_ill = 1)
// so the pc survives for exception reporting; when undefined they are
// accepted and silently dropped, and out_ill is tied low.
//
// Encodings of optype/opcode follow the project def.v:
//   optype CAL=0 CALi=1 LAD=2 STR=3 BRA=4 JUM=5
//   JUM opcodes LUI=0 AUIPC=1 JAL=2 JALR=3; other classes use funct3
//   (CAL and shift-immediates prepend ins[30]).
module issue_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    issue_queue_if.slave     io,
    output logic [PTR_W:0]   count
);
    localparam logic [3:0] OPT_CAL  = 4'd0;
    localparam logic [3:0] OPT_CALI = 4'd1;
    localparam logic [3:0] OPT_LAD  = 4'd2;
    localparam logic [3:0] OPT_STR  = 4'd3;
    localparam logic [3:0] OPT_BRA  = 4'd4;
    localparam logic [3:0] OPT_JUM  = 4'd5;

    localparam logic [3:0] OPC_LUI   = 4'd0;
    localparam logic [3:0] OPC_AUIPC = 4'd1;
    localparam logic [3:0] OPC_JAL   = 4'd2;
    localparam logic [3:0] OPC_JALR  = 4'd3;

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic        rs1_hv;
        logic        rs2_hv;
        logic        rd_hv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  optype;
        logic [3:0]  opcode;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head_ent;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_rd;
    logic            wr_ok;
    logic            push;
    logic            pop;
    logic [2:0]      f3;

    assign f3 = io.in_ins[14:12];

    // Pure decode of the incoming word; register fields zeroed when absent
    always_comb begin
        dec     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (io.in_ins[6:0])
            7'b0110011: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.optype = OPT_CAL;
                dec.opcode = {io.in_ins[30], f3};
            end
            7'b0010011: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec.optype = OPT_CALI;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.imm    = {27'd0, io.in_ins[24:20]};
                    dec.opcode = {io.in_ins[30], f3};
                end else begin
                    dec.imm    = {{20{io.in_ins[31]}}, io.in_ins[31:20]};
                    dec.opcode = {1'b0, f3};
                end
            end
            7'b0000011: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec.optype = OPT_LAD;
                dec.opcode = {1'b0, f3};
                dec.imm    = {{20{io.in_ins[31]}}, io.in_ins[31:20]};
            end
            7'b0100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.optype = OPT_STR;
                dec.opcode = {1'b0, f3};
                dec.imm    = {{20{io.in_ins[31]}}, io.in_ins[31:25], io.in_ins[11:7]};
            end
            7'b1100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec.optype = OPT_BRA;
                dec.opcode = {1'b0, f3};
                dec.imm    = {{20{io.in_ins[31]}}, io.in_ins[7], io.in_ins[30:25],
                              io.in_ins[11:8], 1'b0};
            end
            7'b1101111: begin
                use_rd = 1'b1;
                dec.optype = OPT_JUM;
                dec.opcode = OPC_JAL;
                dec.imm    = {{12{io.in_ins[31]}}, io.in_ins[19:12], io.in_ins[20],
                              io.in_ins[30:21], 1'b0};
            end
            7'b1100111: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                dec.optype = OPT_JUM;
                dec.opcode = OPC_JALR;
                dec.imm    = {{20{io.in_ins[31]}}, io.in_ins[31:20]};
            end
            7'b0010111: begin
                use_rd = 1'b1;
                dec.optype = OPT_JUM;
                dec.opcode = OPC_AUIPC;
                dec.imm    = {io.in_ins[31:12], 12'd0};
            end
            7'b0110111: begin
                use_rd = 1'b1;
                dec.optype = OPT_JUM;
                dec.opcode = OPC_LUI;
                dec.imm    = {io.in_ins[31:12], 12'd0};
            end
            default: begin
                // Unrecognised: leave the all-zero entry (optype CAL, opcode 0)
                legal = 1'b0;
            end
        endcase
        dec.rs1_hv = use_rs1;
        dec.rs2_hv = use_rs2;
        dec.rd_hv  = use_rd && (io.in_ins[11:7] != 5'd0);
        dec.rs1    = use_rs1 ? io.in_ins[19:15] : 5'd0;
        dec.rs2    = use_rs2 ? io.in_ins[24:20] : 5'd0;
        dec.rd     = dec.rd_hv ? io.in_ins[11:7] : 5'd0;
        dec.pc     = io.in_pc;
    end

`ifdef ISSUE_ILL_CHK_EN
    assign wr_ok = 1'b1;
`else
    assign wr_ok = legal;
`endif

    assign io.in_rdy  = (count != FULL);
    assign io.out_vld = (count != '0);
    assign push = rdy_in && io.in_vld && io.in_rdy && !flush && wr_ok;
    assign pop  = rdy_in && io.out_vld && io.out_rdy && !flush;

    // Pointer, occupancy and storage update; flush beats push and pop
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    mem[tail] <= dec;
                    tail      <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

`ifdef ISSUE_ILL_CHK_EN
    logic ill_mem [DEPTH];

    // Illegal flag kept beside each entry, written alongside it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ill_mem[i] <= 1'b0;
            end
        end else if (push) begin
            ill_mem[tail] <= !legal;
        end
    end

    assign io.out_ill = ill_mem[head];
`else
    assign io.out_ill = 1'b0;
`endif

    assign head_ent      = mem[head];
    assign io.out_rs1_hv = head_ent.rs1_hv;
    assign io.out_rs2_hv = head_ent.rs2_hv;
    assign io.out_rd_hv  = head_ent.rd_hv;
    assign io.out_rs1    = head_ent.rs1;
    assign io.out_rs2    = head_ent.rs2;
    assign io.out_rd     = head_ent.rd;
    assign io.out_imm    = head_ent.imm;
    assign io.out_pc     = head_ent.pc;
    assign io.out_optype = head_ent.optype;
    assign io.out_opcode = head_ent.opcode;
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed cases followed by a randomized phase,
// with a reference model of the queue and decoder feeding a scoreboard.
module tb_issue_queue;
    localparam int DEPTH = 4;

    localparam logic [3:0] T_CAL  = 4'd0;
    localparam logic [3:0] T_CALI = 4'd1;
    localparam logic [3:0] T_LAD  = 4'd2;
    localparam logic [3:0] T_STR  = 4'd3;
    localparam logic [3:0] T_BRA  = 4'd4;
    localparam logic [3:0] T_JUM  = 4'd5;
`ifdef ISSUE_ILL_CHK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        ill;
        logic        rs1_hv;
        logic        rs2_hv;
        logic        rd_hv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  optype;
        logic [3:0]  opcode;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic flush = 1'b0;
    logic [2:0] count;
    int checks = 0;
    int failures = 0;
    int occ_pre = 0;
    ent_t exp_q[$];
    ent_t act_ent;
    ent_t exp_ent;
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h37};

    issue_queue_if io ();

    issue_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .flush  (flush),
        .io     (io),
        .count  (count)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic bit legal_op(input logic [31:0] w);
        return w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h37};
    endfunction

    // Reference decoder: pick the format, then fill fields from it
    function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        ent_t e;
        logic r1, r2, rd;
        logic [2:0] f3;
        e = '0; r1 = 0; r2 = 0; rd = 0;
        f3 = w[14:12];
        e.pc = pc;
        case (w[6:0])
            7'h33: begin r1 = 1; r2 = 1; rd = 1; e.optype = T_CAL; e.opcode = {w[30], f3}; end
            7'h13: begin
                r1 = 1; rd = 1; e.optype = T_CALI;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm = 32'(w[24:20]); e.opcode = {w[30], f3};
                end else begin
                    e.imm = 32'($signed(w[31:20])); e.opcode = {1'b0, f3};
                end
            end
            7'h03: begin r1 = 1; rd = 1; e.optype = T_LAD; e.opcode = {1'b0, f3}; e.imm = 32'($signed(w[31:20])); end
            7'h23: begin r1 = 1; r2 = 1; e.optype = T_STR; e.opcode = {1'b0, f3};
                e.imm = 32'($signed({w[31:25], w[11:7]})); end
            7'h63: begin r1 = 1; r2 = 1; e.optype = T_BRA; e.opcode = {1'b0, f3};
                e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
            7'h6f: begin rd = 1; e.optype = T_JUM; e.opcode = 4'd2;
                e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h67: begin r1 = 1; rd = 1; e.optype = T_JUM; e.opcode = 4'd3; e.imm = 32'($signed(w[31:20])); end
            7'h17: begin rd = 1; e.optype = T_JUM; e.opcode = 4'd1; e.imm = w & 32'hFFFF_F000; end
            7'h37: begin rd = 1; e.optype = T_JUM; e.opcode = 4'd0; e.imm = w & 32'hFFFF_F000; end
            default: e.ill = ILL_EN;
        endcase
        e.rs1_hv = r1;
        e.rs2_hv = r2;
        if (r1) e.rs1 = w[19:15];
        if (r2) e.rs2 = w[24:20];
        if (rd && w[11:7] != 5'd0) begin
            e.rd_hv = 1'b1;
            e.rd = w[11:7];
        end
        return e;
    endfunction

    // Reference queue: accept/flush on each enabled edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            occ_pre = 0;
        end else if (rdy) begin
            if (flush) begin
                exp_q.delete();
            end else if (io.in_vld && occ_pre < DEPTH && (ILL_EN || legal_op(io.in_ins))) begin
                exp_q.push_back(ref_decode(io.in_ins, io.in_pc));
            end
        end
    end

    // Monitor: occupancy flags every cycle, full entry compare on each pop
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 128'(count), 128'(exp_q.size()));
            chk("out_vld", 128'(io.out_vld), 128'(exp_q.size() != 0));
            chk("in_rdy", 128'(io.in_rdy), 128'(exp_q.size() < DEPTH));
            occ_pre = exp_q.size();
            if (rdy && !flush && io.out_rdy && exp_q.size() != 0) begin
                exp_ent = exp_q.pop_front();
                act_ent = '{io.out_ill, io.out_rs1_hv, io.out_rs2_hv, io.out_rd_hv,
                            io.out_rs1, io.out_rs2, io.out_rd, io.out_imm, io.out_pc,
                            io.out_optype, io.out_opcode};
                chk("pop_entry", 128'(act_ent), 128'(exp_ent));
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] pc);
        io.in_vld = 1'b1; io.in_ins = w; io.in_pc = pc;
        cyc();
        io.in_vld = 1'b0;
    endtask

    task automatic pop_n(input int n);
        io.out_rdy = 1'b1;
        repeat (n) cyc();
        io.out_rdy = 1'b0;
    endtask

    initial begin
        io.in_vld = 1'b0; io.in_ins = '0; io.in_pc = '0; io.out_rdy = 1'b0;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_out_vld", 128'(io.out_vld), 128'd0);
        chk("rst_in_rdy", 128'(io.in_rdy), 128'd1);
        chk("rst_out_pc", 128'(io.out_pc), 128'd0);
        chk("rst_out_imm", 128'(io.out_imm), 128'd0);
        rst = 1'b0;
        cyc();

        // ADDI x1, x0, 5
        push(32'h0050_0093, 32'h100);
        chk("addi_vld", 128'(io.out_vld), 128'd1);
        chk("addi_rd", 128'({io.out_rd_hv, io.out_rd}), 128'({1'b1, 5'd1}));
        chk("addi_rs", 128'({io.out_rs1_hv, io.out_rs1, io.out_rs2_hv}), 128'({1'b1, 5'd0, 1'b0}));
        chk("addi_imm", 128'(io.out_imm), 128'd5);
        chk("addi_op", 128'({io.out_optype, io.out_opcode}), 128'({T_CALI, 4'd0}));
        chk("addi_pc", 128'(io.out_pc), 128'h100);
        pop_n(1);

        // LUI x2, 0x12345
        push(32'h1234_5137, 32'h104);
        chk("lui_imm", 128'(io.out_imm), 128'h1234_5000);
        chk("lui_hv", 128'({io.out_rs1_hv, io.out_rs2_hv, io.out_rd_hv, io.out_rd}), 128'({3'b001, 5'd2}));
        chk("lui_op", 128'({io.out_optype, io.out_opcode}), 128'({T_JUM, 4'd0}));
        pop_n(1);

        // SRAI x3, x3, 4
        push(32'h4041_D193, 32'h108);
        chk("srai_imm", 128'(io.out_imm), 128'd4);
        chk("srai_opc", 128'(io.out_opcode), 128'hD);
        pop_n(1);

        // ADDI x0, x0, 0
        push(32'h0000_0013, 32'h10C);
        chk("x0_rd_hv", 128'(io.out_rd_hv), 128'd0);
        pop_n(1);

        // Fill to full, fifth push refused
        for (int i = 0; i < 4; i++) push(32'h0000_0093 | (32'(i) << 20), 32'h200 + 32'(4 * i));
        chk("full_count", 128'(count), 128'd4);
        chk("full_in_rdy", 128'(io.in_rdy), 128'd0);
        push(32'h0070_0093, 32'h210);
        chk("full_hold", 128'(count), 128'd4);
        pop_n(4);
        chk("drained", 128'(count), 128'd0);

        // Simultaneous push and pop at count 2
        push(32'h0010_0113, 32'h300);
        push(32'h0020_0113, 32'h304);
        io.out_rdy = 1'b1;
        push(32'h0030_0113, 32'h308);
        io.out_rdy = 1'b0;
        chk("pushpop_count", 128'(count), 128'd2);
        pop_n(2);

        // Wrap-around: ten back-to-back pushes with continuous pop
        io.out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) push(32'h0000_0033 | (32'(i) << 15), 32'h400 + 32'(4 * i));
        cyc();
        io.out_rdy = 1'b0;
        chk("wrap_empty", 128'(count), 128'd0);

        // Flush with a same-cycle push
        for (int i = 0; i < 3; i++) push(32'h0000_0513, 32'h500 + 32'(4 * i));
        flush = 1'b1;
        push(32'h0000_0593, 32'hDEAD);
        flush = 1'b0;
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_vld", 128'(io.out_vld), 128'd0);
        push(32'h0000_0613, 32'h600);
        chk("after_flush_pc", 128'(io.out_pc), 128'h600);
        pop_n(1);

        // Stall: nothing moves while rdy_in is low
        push(32'h0000_0693, 32'h700);
        push(32'h0000_0713, 32'h704);
        rdy = 1'b0;
        io.in_vld = 1'b1; io.in_ins = 32'h0000_0793; io.in_pc = 32'h708;
        io.out_rdy = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_count", 128'(count), 128'd2);
            chk("stall_pc", 128'(io.out_pc), 128'h700);
        end
        io.in_vld = 1'b0; io.out_rdy = 1'b0; flush = 1'b0;
        rdy = 1'b1;
        pop_n(2);

        // Illegal word
        push(32'hFFFF_FFFF, 32'h800);
`ifdef ISSUE_ILL_CHK_EN
        chk("ill_flag", 128'(io.out_ill), 128'd1);
        chk("ill_pc", 128'(io.out_pc), 128'h800);
        chk("ill_count", 128'(count), 128'd1);
        pop_n(1);
`else
        chk("ill_count", 128'(count), 128'd0);
        chk("ill_vld", 128'(io.out_vld), 128'd0);
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            logic [31:0] w;
            w = $urandom();
            if ($urandom_range(0, 9) == 0) w[6:0] = 7'h7F;
            else w[6:0] = ops[$urandom_range(0, 8)];
            io.in_vld  = ($urandom_range(0, 2) != 0);
            io.in_ins  = w;
            io.in_pc   = $urandom() & 32'hFFFF_FFFC;
            io.out_rdy = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            rdy        = ($urandom_range(0, 9) != 0);
            cyc();
        end
        io.in_vld = 1'b0; flush = 1'b0; rdy = 1'b1; io.out_rdy = 1'b0;

        // Asynchronous reset in the middle of a cycle
        push(32'h0000_0813, 32'h900);
        push(32'h0000_0893, 32'h904);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_vld", 128'(io.out_vld), 128'd0);
        chk("async_rst_count", 128'(count), 128'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Final drain
        push(32'h0000_0913, 32'hA00);
        pop_n(DEPTH + 2);
        chk("final_empty", 128'(count), 128'd0);
        chk("final_model_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Registered decode-and-buffer stage between instruction fetch and the reservation station / ROB dispatch logic.
- Each accepted RV32I instruction word is decoded into register fields, immediate, optype and opcode, then stored with its pc in a DEPTH-entry circular FIFO.
- Downstream pops entries with a valid/ready handshake.
- Supports pipeline flush on branch mispredict and stall on rdy_in.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- rdy_in  input  1  global enable; when low, all state holds.
- flush  input  1  clears the queue (mispredict).
- in_vld  input  1  fetch offers an instruction.
- in_ins  input  32  instruction word.
- in_pc  input  32  pc of in_ins.
- in_rdy  output  1  queue can accept; equals NOT full.
- out_vld  output  1  head entry valid.
- out_rdy  input  1  downstream takes head this cycle.
- out_rs1_hv, out_rs2_hv, out_rd_hv  output  1 each  operand/destination present.
- out_rs1, out_rs2, out_rd  output  5 each  register indices.
- out_imm  output  32  sign/zero-formed immediate.
- out_pc  output  32  pc of head entry.
- out_optype  output  4  `CAL/`CALi/`STR/`LAD/`BRA/`JUM from def.v.
- out_opcode  output  4  sub-op code, encoded per def.v.
- out_ill  output  1  head entry is an illegal instruction (see Optional Feature).
- count  output  PTR_W+1  number of occupied entries.

Behaviour:
- Reset (async, rst_in high): head, tail and count = 0; out_vld = 0; every stored field and every out_* field = 0; in_rdy = 1.
- Push: when rdy_in & in_vld & in_rdy & ~flush, write the decoded entry at tail; tail <= tail+1 mod DEPTH.
- Pop: when rdy_in & out_vld & out_rdy & ~flush, head <= head+1 mod DEPTH.
- Simultaneous push and pop: count unchanged. in_rdy does not look ahead to a same-cycle pop, so a full queue accepts nothing that cycle.
- Latency: an instruction accepted at edge N is visible at the output after edge N (out_vld = 1 in cycle N+1). No combinational path from in_* to out_*.
- Outputs are driven from the head entry registers. out_vld = (count != 0).
- Pop when empty and push when full are ignored; no state change.
- flush: on the next edge (when rdy_in is high), head = tail = count = 0 and out_vld = 0. flush has priority over same-cycle push and pop.
- rdy_in low: no push, pop or flush takes effect; outputs hold.
- Decode, per entry:
  - rs1 = ins[19:15], rs2 = ins[24:20], rd = ins[11:7]. Any field whose _hv is 0 is stored as 0.
  - Per-opcode _hv, imm, optype and opcode: identical to the existing RV32I decode rules (CAL imm = 0; shift-immediate imm = ins[24:20] with opcode {ins[30], funct3}; other I-type sign-extended; S, B, J, U formats; JAL/JALR/AUIPC/LUI opcodes per def.v).
  - New: rd_hv is forced to 0 when rd == 0.
  - Decoding is a pure function of the word; there are no latches and no state held from the previous instruction.
- Unknown opcode: see Optional Feature.

Optional Feature:
- Macro: ISSUE_ILL_CHK_EN.
- Defined:
  - An instruction with an unrecognised ins[6:0] is still enqueued.
  - Its entry has out_ill = 1, all _hv = 0, imm = 0, optype = `CAL, opcode = 0.
  - Its pc is preserved for exception reporting.
- Undefined:
  - An unrecognised instruction is accepted when in_rdy is high but is not written; count and tail do not change.
  - out_ill is tied to 0.

Test Plan:
- Decode ADDI: push 0x00500093 at pc 0x100 → next cycle out_vld = 1, rd = 1, rd_hv = 1, rs1_hv = 1, rs1 = 0, rs2_hv = 0, imm = 5, optype `CALi, opcode 0, out_pc = 0x100.
- Decode LUI and SRAI:
  - LUI 0x12345137 → imm 0x12345000, rs1_hv = rs2_hv = 0, rd = 2, opcode `LUI.
  - SRAI 0x4041D193 → imm 4, opcode 4'b1101.
- Full and x0 destination:
  - Push 5 instructions with out_rdy = 0 → after the 4th, count = 4 and in_rdy = 0; the 5th is not stored; the 4 pop out in FIFO order.
  - ADDI x0,x0,0 (0x00000013) → rd_hv = 0.
- Simultaneous push and pop at count = 2 → count stays 2. Wrap-around across 10 pushes and pops → pcs pop out in order.
- Flush and stall:
  - With count = 3, assert flush together with in_vld → next cycle count = 0, out_vld = 0, and the flushed-cycle instruction is absent.
  - rdy_in = 0 for 3 cycles → all state frozen.
  - Assert rst_in mid-stream → out_vld = 0 immediately (asynchronously).
- Illegal word: push 0xFFFFFFFF:
  - With ISSUE_ILL_CHK_EN: entry with out_ill = 1.
  - Without it: count unchanged and out_vld stays 0.
